// File: rtl/mux3s_rr_arbiter_if.sv
// Handshake bundle between the mux3s round-robin arbiter and its surroundings.
// master: the arbiter side (drives grant, select, valid, error).
// slave : the requester/consumer side.
interface mux3s_rr_arbiter_if;
   logic [2:0] req_i;
   logic [2:0] last_i;
   logic [2:0] gnt_o;
   logic [1:0] sel_o;
   logic       valid_o;
   logic       ready_i;
   logic       err_o;

   modport master (
      input  req_i,
      input  last_i,
      input  ready_i,
      output gnt_o,
      output sel_o,
      output valid_o,
      output err_o
   );

   modport slave (
      output req_i,
      output last_i,
      output ready_i,
      input  gnt_o,
      input  sel_o,
      input  valid_o,
      input  err_o
   );
endinterface

// File: rtl/mux3s_rr_arbiter.sv
// Round-robin burst arbiter driving the select pins of a mux3s 3:1 mux.
// One requester is granted at a time; the grant is released on a last beat,
// after MaxBeats transfers (0 = unlimited), or, when the optional feature is
// built, after TimeoutCycles consecutive cycles with the granted request low.
// Optional feature macro: MUX3S_RR_ARBITER_TIMEOUT_EN (idle timeout + err_o).
module mux3s_rr_arbiter #(
   parameter int MaxBeats      = 16,
   parameter int TimeoutCycles = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   mux3s_rr_arbiter_if.master    bus
);

   localparam int CntW     = (MaxBeats == 0) ? 1 : $clog2(MaxBeats + 1);
   localparam int LastBeat = (MaxBeats == 0) ? 0 : MaxBeats - 1;

   if (TimeoutCycles < 1) begin : g_bad_timeout
      $error("TimeoutCycles must be >= 1");
   end

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        g_q, g_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        sel_q, sel_d;

`ifdef MUX3S_RR_ARBITER_TIMEOUT_EN
   localparam int IdleW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);
   logic [IdleW-1:0]  idle_q, idle_d;
`endif

   // Search ptr, ptr+1, ptr+2 (mod 3); returns {found, index}.
   function automatic logic [2:0] pick(input logic [1:0] p, input logic [2:0] r);
      logic       found;
      logic [1:0] idx;
      logic [1:0] c;
      found = 1'b0;
      idx   = 2'd0;
      for (int unsigned k = 0; k < 3; k++) begin
         c = 2'((32'(p) + k) % 3);
         if (!found && r[c]) begin
            found = 1'b1;
            idx   = c;
         end
      end
      return {found, idx};
   endfunction

   // mux3s select encoding: i0=10, i1=11, i2=00.
   function automatic logic [1:0] enc(input logic [1:0] g);
      case (g)
         2'd0:    return 2'b10;
         2'd1:    return 2'b11;
         2'd2:    return 2'b00;
         default: return 2'b10;
      endcase
   endfunction

   function automatic logic [1:0] next_ptr(input logic [1:0] g);
      return (g == 2'd2) ? 2'd0 : g + 2'd1;
   endfunction

   // State, grant index, pointer, beat counter and select register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         g_q     <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= '0;
         sel_q   <= 2'b10;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
      end
   end

`ifdef MUX3S_RR_ARBITER_TIMEOUT_EN
   // Consecutive-cycles-without-request counter for the granted requester.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) idle_q <= '0;
      else       idle_q <= idle_d;
   end
`endif

   // Next-state, arbitration and handshake outputs.
   always_comb begin
      logic [2:0] gnt_vec;
      logic       req_g;
      logic       last_g;
      logic       xfer;
      logic       rel;
      logic [1:0] np;
      logic [2:0] win;

      state_d = state_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      gnt_vec = 3'b000;
      req_g   = 1'b0;
      last_g  = 1'b0;
      xfer    = 1'b0;
      rel     = 1'b0;
      np      = ptr_q;
      win     = 3'b000;
      bus.gnt_o   = 3'b000;
      bus.valid_o = 1'b0;
      bus.err_o   = 1'b0;
`ifdef MUX3S_RR_ARBITER_TIMEOUT_EN
      idle_d  = '0;
`endif

      case (state_q)
         ST_IDLE: begin
            win = pick(ptr_q, bus.req_i);
            if (win[2]) begin
               state_d = ST_GRANT;
               g_d     = win[1:0];
               cnt_d   = '0;
               sel_d   = enc(win[1:0]);
            end
         end

         ST_GRANT: begin
            gnt_vec     = 3'b001 << g_q;
            req_g       = |(bus.req_i & gnt_vec);
            last_g      = |(bus.last_i & gnt_vec);
            bus.gnt_o   = gnt_vec;
            bus.valid_o = req_g;
            xfer        = req_g && bus.ready_i;
            rel         = xfer && (last_g ||
                          ((MaxBeats != 0) && (cnt_q == CntW'(LastBeat))));
`ifdef MUX3S_RR_ARBITER_TIMEOUT_EN
            if (!req_g) begin
               if (idle_q == IdleW'(TimeoutCycles - 1)) begin
                  bus.err_o = 1'b1;
                  rel       = 1'b1;
               end else begin
                  idle_d = idle_q + IdleW'(1);
               end
            end
`endif
            if (rel) begin
               // Re-arbitrate from the advanced pointer in the release cycle
               // so back-to-back grants carry no bubble.
               np    = next_ptr(g_q);
               ptr_d = np;
               cnt_d = '0;
               win   = pick(np, bus.req_i);
               if (win[2]) begin
                  g_d   = win[1:0];
                  sel_d = enc(win[1:0]);
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (xfer && (MaxBeats != 0)) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.sel_o = sel_q;

endmodule
